tt_response_checker: RTL and testbench

Self-checking response sequencer for small combinational function blocks: on `start` it drives every input vector of an `N_IN`-input single-output DUT in ascending binary order and samples the DUT output after a programmable settle time. Each sample is compared against a caller-supplied truth table. At the end of the sweep it reports pass/fail, the mismatch count and the first failing vector. It sits opposite the DUT in lab-project test harnesses, replacing hand-written per-vector stimulus with a synthesizable sweep-and-check engine.

---
 rtl/tt_response_checker_if.sv | 44 ++++
 rtl/tt_response_checker.sv | 103 ++++++++++
 tb/tb_tt_response_checker.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/tt_response_checker_if.sv
// Bundle between the sweep-and-check engine and its harness:
// control, truth table, DUT stimulus/response and results.
interface tt_response_checker_if #(
   parameter int N_IN = 3
);
   localparam int V = 1 << N_IN;

   logic            start;
   logic [V-1:0]    expected;
   logic [N_IN-1:0] vec_out;
   logic            f_in;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_count;
   logic [N_IN-1:0] first_err_idx;
   logic            first_err_valid;

   modport master (
      input  start,
      input  expected,
      input  f_in,
      output vec_out,
      output busy,
      output done,
      output pass,
      output err_count,
      output first_err_idx,
      output first_err_valid
   );

   modport slave (
      output start,
      output expected,
      output f_in,
      input  vec_out,
      input  busy,
      input  done,
      input  pass,
      input  err_count,
      input  first_err_idx,
      input  first_err_valid
   );
endinterface

// File: rtl/tt_response_checker.sv
// Exhaustive truth-table sweep of an N_IN-input DUT with
// per-vector settle delay, mismatch count and first-fail index.
module tt_response_checker #(
   parameter int N_IN          = 3,
   parameter int SETTLE_CYCLES = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   tt_response_checker_if.master bus
);
   localparam int V = 1 << N_IN;
   localparam logic [N_IN-1:0] LAST = N_IN'(V - 1);
   localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   state_t          state;
   logic [3:0]      cnt;
   logic [V-1:0]    exp_q;
   logic [N_IN-1:0] vec_q;
   logic [N_IN:0]   err_q;
   logic [N_IN-1:0] fei_q;
   logic            fev_q;
   logic            busy_q;
   logic            done_q;
   logic            pass_q;
   logic            miss;
   logic [N_IN:0]   err_nxt;

   // Case-inequality so an X/Z response is a mismatch in sim.
   assign miss    = (bus.f_in !== exp_q[vec_q]);
   assign err_nxt = err_q + {{N_IN{1'b0}}, miss};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         exp_q  <= '0;
         vec_q  <= '0;
         err_q  <= '0;
         fei_q  <= '0;
         fev_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  state  <= SETTLE;
                  cnt    <= RELOAD;
                  exp_q  <= bus.expected;
                  vec_q  <= '0;
                  err_q  <= '0;
                  fei_q  <= '0;
                  fev_q  <= 1'b0;
                  pass_q <= 1'b0;
                  busy_q <= 1'b1;
               end
            end
            SETTLE: begin
               if (cnt <= 4'd1) state <= SAMPLE;
               else             cnt   <= cnt - 4'd1;
            end
            SAMPLE: begin
               err_q <= err_nxt;
               if (miss && !fev_q) begin
                  fev_q <= 1'b1;
                  fei_q <= vec_q;
               end
               if (vec_q == LAST) begin
                  state  <= DONE;
                  done_q <= 1'b1;
                  pass_q <= (err_nxt == '0);
               end else begin
                  state <= SETTLE;
                  vec_q <= vec_q + 1'b1;
                  cnt   <= RELOAD;
               end
            end
            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.vec_out         = vec_q;
   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.pass            = pass_q;
   assign bus.err_count       = err_q;
   assign bus.first_err_idx   = fei_q;
   assign bus.first_err_valid = fev_q;
endmodule

// File: tb/tb_tt_response_checker.sv
// Directed bench: default checker on f=(x&y)|z or tied-0,
// plus a SETTLE_CYCLES=3 checker behind a 2-stage DUT.
module tb_tt_response_checker;
   logic clk;
   logic rst_n;
   logic sel0;
   logic p1, p2;
   int   n_cmp;
   int   n_bad;

   tt_response_checker_if #(.N_IN(3)) if0 ();
   tt_response_checker_if #(.N_IN(3)) if1 ();

   tt_response_checker #(
      .N_IN(3),
      .SETTLE_CYCLES(1)
   ) dut0 (
      .clk(clk),
      .rst_n(rst_n),
      .bus(if0)
   );

   tt_response_checker #(
      .N_IN(3),
      .SETTLE_CYCLES(3)
   ) dut1 (
      .clk(clk),
      .rst_n(rst_n),
      .bus(if1)
   );

   function automatic logic fxyz(input logic [2:0] v);
      return (v[2] & v[1]) | v[0];
   endfunction

   assign if0.f_in = sel0 ? 1'b0 : fxyz(if0.vec_out);

   always_ff @(posedge clk) begin
      p1 <= fxyz(if1.vec_out);
      p2 <= p1;
   end
   assign if1.f_in = p2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic start0(input logic [7:0] e);
      @(negedge clk);
      if0.expected = e;
      if0.start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if0.start = 1'b0;
   endtask

   // Returns edge count after the accepting edge; -1 on timeout.
   task automatic wait_done0(input int hold, output int n);
      n = -1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (hold > 0 && k < 8 * hold) begin
            chk("vec_step", 32'(if0.vec_out), k / hold);
            chk("busy_mid", 32'(if0.busy), 1);
         end
         if (if0.done) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic res0(input string tag, input logic p,
                       input logic [3:0] e, input logic v,
                       input logic [2:0] i);
      chk({tag, "_pass"}, 32'(if0.pass), 32'(p));
      chk({tag, "_errc"}, 32'(if0.err_count), 32'(e));
      chk({tag, "_fev"}, 32'(if0.first_err_valid), 32'(v));
      chk({tag, "_fei"}, 32'(if0.first_err_idx), 32'(i));
   endtask

   task automatic zero0(input string tag);
      chk({tag, "_vec"}, 32'(if0.vec_out), 0);
      chk({tag, "_busy"}, 32'(if0.busy), 0);
      chk({tag, "_done"}, 32'(if0.done), 0);
      res0(tag, 1'b0, 4'd0, 1'b0, 3'd0);
   endtask

   initial begin
      int n;
      int nd;
      int dk;
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      sel0  = 1'b0;
      if0.start    = 1'b0;
      if0.expected = '0;
      if1.start    = 1'b0;
      if1.expected = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      zero0("rst");
      rst_n = 1'b1;

      // Correct DUT
      start0(8'hEA);
      wait_done0(2, n);
      chk("ok_lat", n, 16);
      chk("ok_vec_last", 32'(if0.vec_out), 7);
      res0("ok", 1'b1, 4'd0, 1'b0, 3'd0);
      @(posedge clk);
      @(negedge clk);
      chk("ok_busy_fall", 32'(if0.busy), 0);
      chk("ok_done_pulse", 32'(if0.done), 0);
      chk("ok_vec_hold", 32'(if0.vec_out), 7);
      chk("ok_pass_hold", 32'(if0.pass), 1);

      // Single error at vector 0
      start0(8'hEB);
      wait_done0(0, n);
      chk("one_lat", n, 16);
      res0("one", 1'b0, 4'd1, 1'b1, 3'd0);

      // Every vector wrong
      sel0 = 1'b1;
      start0(8'hFF);
      wait_done0(0, n);
      chk("all_lat", n, 16);
      res0("all", 1'b0, 4'd8, 1'b1, 3'd0);
      sel0 = 1'b0;

      // Extra start and table change during a sweep
      start0(8'hEA);
      nd = 0;
      dk = -1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 4) begin
            if0.start    = 1'b1;
            if0.expected = 8'h00;
         end
         if (k == 5) if0.start = 1'b0;
         if (if0.done) begin
            nd++;
            if (dk < 0) dk = k;
         end
      end
      chk("ign_ndone", nd, 1);
      chk("ign_lat", dk, 16);
      res0("ign", 1'b1, 4'd0, 1'b0, 3'd0);

      // Start held: back-to-back sweeps
      @(negedge clk);
      if0.expected = 8'hEB;
      if0.start    = 1'b1;
      @(posedge clk);
      nd = 0;
      n  = -1;
      for (int k = 1; k <= 80; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (if0.done) begin
            nd++;
            if (nd == 1) begin
               chk("held_lat1", k, 16);
               res0("held1", 1'b0, 4'd1, 1'b1, 3'd0);
               if0.expected = 8'hEA;
            end else begin
               n = k;
               if0.start = 1'b0;
               break;
            end
         end
      end
      chk("held_lat2", n, 34);
      res0("held2", 1'b1, 4'd0, 1'b0, 3'd0);
      repeat (4) @(posedge clk);

      // Reset mid-sweep
      start0(8'hEA);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 zero0("mrst");
      nd = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (if0.done) nd++;
      end
      chk("mrst_nodone", nd, 0);
      rst_n = 1'b1;
      start0(8'hEA);
      wait_done0(2, n);
      chk("mrst_lat", n, 16);
      res0("mrst_ok", 1'b1, 4'd0, 1'b0, 3'd0);

      // SETTLE_CYCLES=3 behind a 2-cycle DUT
      @(negedge clk);
      if1.expected = 8'hEA;
      if1.start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if1.start = 1'b0;
      n = -1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k < 32)
            chk("s3_vec", 32'(if1.vec_out), k / 4);
         if (if1.done) begin
            n = k;
            break;
         end
      end
      chk("s3_lat", n, 32);
      chk("s3_pass", 32'(if1.pass), 1);
      chk("s3_errc", 32'(if1.err_count), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
